// File: rtl/fan_speed_ctrl.sv
// Fan speed front end: four debounced panel buttons set a 0-3 speed level, with an optional auto-off timer (FAN_TIMER_EN).
// Raw press to registered outputs is exactly DEBOUNCE_CNT+3 cycles; there is no backpressure and presses are never stalled.
module fan_speed_ctrl #(
  parameter int DEBOUNCE_CNT = 2000,
  parameter int TICK_DIV     = 100000,
  parameter int TIMER_STEP_S = 60
) (
  input  logic       i_100kHz,
  input  logic       i_rst_n,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_off,
  input  logic       i_btn_timer,
  output logic [1:0] o_FANspeed,
  output logic [1:0] o_timer_sel,
  output logic       o_timer_active,
  output logic       o_event
);

`ifdef FAN_TIMER_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0] lvl_q, lvl_d, lvl_last_q, lvl_last_d, press_q, press_d;
  logic [DW-1:0] cnt_q [NB];
  logic [DW-1:0] cnt_d [NB];
  logic [1:0]    speed_q, speed_d;
  logic          event_q, event_d;
  logic          up_p, dn_p, off_p;
  logic          expire, sel_chg;

`ifdef FAN_TIMER_EN
  assign raw = {i_btn_timer, i_btn_off, i_btn_down, i_btn_up};
`else
  logic unused_btn_timer;
  assign unused_btn_timer = i_btn_timer;
  assign raw = {i_btn_off, i_btn_down, i_btn_up};
`endif

  assign up_p  = press_q[0];
  assign dn_p  = press_q[1];
  assign off_p = press_q[2];

  // Count the final mismatching cycle too, so the level flips on the DEBOUNCE_CNT-th one.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    lvl_last_d = lvl_q;
    press_d    = lvl_q & ~lvl_last_q;
    lvl_d      = lvl_q;
    for (int b = 0; b < NB; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != lvl_q[b]) begin
        if (cnt_q[b] == DB_LAST) lvl_d[b] = sync2_q[b];
        else                     cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  always_comb begin
    speed_d = speed_q;
    if (expire || off_p) begin
      speed_d = 2'd0;
    end else if (up_p && dn_p) begin
      speed_d = speed_q;
    end else if (up_p) begin
      if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
    end else if (dn_p) begin
      if (speed_q != 2'd0) speed_d = speed_q - 2'd1;
    end
    event_d = !expire && ((speed_d != speed_q) || sel_chg);
  end

  always_ff @(posedge i_100kHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_last_q <= '0;
      press_q    <= '0;
      for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
      speed_q    <= 2'd0;
      event_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      lvl_last_q <= lvl_last_d;
      press_q    <= press_d;
      cnt_q      <= cnt_d;
      speed_q    <= speed_d;
      event_q    <= event_d;
    end
  end

  assign o_FANspeed = speed_q;
  assign o_event    = event_q;

`ifdef FAN_TIMER_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(3 * TIMER_STEP_S + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [1:0]    sel_q, sel_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          active_q, active_d;
  logic          tmr_p;

  assign tmr_p   = press_q[3];
  assign expire  = (sel_q != 2'd0) && (presc_q == P_LAST) && (rem_q == RW'(1));
  assign sel_chg = (sel_d != sel_q);

  always_comb begin
    sel_d   = sel_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    if (sel_q != 2'd0) begin
      if (presc_q == P_LAST) begin
        presc_d = '0;
        rem_d   = rem_q - 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (tmr_p && (speed_q != 2'd0)) begin
      sel_d   = sel_q + 2'd1;
      presc_d = '0;
      case (sel_d)
        2'd1:    rem_d = RW'(TIMER_STEP_S);
        2'd2:    rem_d = RW'(2 * TIMER_STEP_S);
        2'd3:    rem_d = RW'(3 * TIMER_STEP_S);
        default: rem_d = '0;
      endcase
    end
    // Landing on speed 0 always disarms, even if a timer press arrived alongside.
    if (speed_d == 2'd0) begin
      sel_d   = 2'd0;
      rem_d   = '0;
      presc_d = '0;
    end
    active_d = (sel_d != 2'd0);
  end

  always_ff @(posedge i_100kHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_q    <= 2'd0;
      rem_q    <= '0;
      presc_q  <= '0;
      active_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      rem_q    <= rem_d;
      presc_q  <= presc_d;
      active_q <= active_d;
    end
  end

  assign o_timer_sel    = sel_q;
  assign o_timer_active = active_q;
`else
  assign expire         = 1'b0;
  assign sel_chg        = 1'b0;
  assign o_timer_sel    = 2'd0;
  assign o_timer_active = 1'b0;
`endif

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Random and directed stimulus for fan_speed_ctrl, checked every cycle against an event-level model.
module tb_fan_speed_ctrl;
  localparam int D    = 4;
  localparam int DIV  = 10;
  localparam int STEP = 2;
`ifdef FAN_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic       clk;
  logic       i_rst_n;
  logic [3:0] btn;
  logic [1:0] o_FANspeed, o_timer_sel;
  logic       o_timer_active, o_event;

  fan_speed_ctrl #(.DEBOUNCE_CNT(D), .TICK_DIV(DIV), .TIMER_STEP_S(STEP)) dut (
    .i_100kHz      (clk),
    .i_rst_n       (i_rst_n),
    .i_btn_up      (btn[0]),
    .i_btn_down    (btn[1]),
    .i_btn_off     (btn[2]),
    .i_btn_timer   (btn[3]),
    .o_FANspeed    (o_FANspeed),
    .o_timer_sel   (o_timer_sel),
    .o_timer_active(o_timer_active),
    .o_event       (o_event)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ev_seen = 0;

  // Model: a button level is accepted once the last D raw samples all
  // disagree with it; an accepted press acts on the outputs 4 edges later.
  int m_speed, m_sel, m_deadline;
  bit m_event;
  bit m_lvl [4];
  logic [31:0] hist [4];
  int hlen [4];
  int due_q[$];
  int btn_q[$];

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_speed = 0; m_sel = 0; m_event = 0; m_deadline = 0;
    for (int b = 0; b < 4; b++) begin
      m_lvl[b] = 0; hist[b] = '0; hlen[b] = 0;
    end
    due_q.delete();
    btn_q.delete();
  endfunction

  function automatic void model_edge(int e);
    bit p [4];
    bit expd;
    int old_speed, old_sel;
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) p[b] = 0;
    while (due_q.size() > 0 && due_q[0] == e) begin
      p[btn_q[0]] = 1;
      void'(due_q.pop_front());
      void'(btn_q.pop_front());
    end
    expd = (m_sel != 0) && (e == m_deadline);
    old_speed = m_speed;
    old_sel = m_sel;
    if (expd || p[2]) m_speed = 0;
    else if (p[0] && p[1]) m_speed = m_speed;
    else if (p[0]) m_speed = (m_speed + 1 > 3) ? 3 : m_speed + 1;
    else if (p[1]) m_speed = (m_speed - 1 < 0) ? 0 : m_speed - 1;
    if (TIMER_EN && p[3] && old_speed != 0) begin
      m_sel = (m_sel + 1) % 4;
      m_deadline = e + m_sel * STEP * DIV;
    end
    if (m_speed == 0) m_sel = 0;
    m_event = !expd && (m_speed != old_speed || m_sel != old_sel);

    mask = (32'd1 << D) - 32'd1;
    for (int b = 0; b < 4; b++) begin
      hist[b] = {hist[b][30:0], btn[b]};
      if (hlen[b] < D) hlen[b]++;
      if (hlen[b] == D && ((hist[b] & mask) == (m_lvl[b] ? 32'd0 : mask))) begin
        m_lvl[b] = !m_lvl[b];
        if (m_lvl[b]) begin
          due_q.push_back(e + 4);
          btn_q.push_back(b);
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!i_rst_n) model_reset();
    else model_edge(cyc);
    #1;
    if (o_event) ev_seen++;
    chk("speed", o_FANspeed, m_speed);
    chk("timer_sel", o_timer_sel, m_sel);
    chk("timer_active", o_timer_active, (m_sel != 0) ? 1 : 0);
    chk("event", o_event, m_event);
  endtask

  task automatic do_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_speed", o_FANspeed, 0);
    chk("rst_sel", o_timer_sel, 0);
    chk("rst_active", o_timer_active, 0);
    chk("rst_event", o_event, 0);
    model_reset();
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic press(logic [3:0] mask);
    btn = mask;
    repeat (D + 1) step();
    btn = 4'b0000;
    repeat (D + 3) step();
  endtask

  initial begin
    int ev0;
    logic [3:0] m;
    i_rst_n = 1'b1;
    btn = 4'b0000;
    model_reset();
    do_reset();

    // Held up: exact latency, single event, nothing more while held.
    btn = 4'b0001;
    ev0 = ev_seen;
    repeat (7) step();
    chk("lat_early", o_FANspeed, 0);
    step();
    chk("lat_speed", o_FANspeed, 1);
    chk("lat_event", o_event, 1);
    repeat (12) step();
    btn = 4'b0000;
    repeat (D + 3) step();
    chk("hold_events", ev_seen - ev0, 1);

    do_reset();
    ev0 = ev_seen;
    repeat (4) press(4'b0001);
    chk("up_sat", o_FANspeed, 3);
    chk("up_events", ev_seen - ev0, 3);
    ev0 = ev_seen;
    repeat (4) press(4'b0010);
    chk("down_sat", o_FANspeed, 0);
    chk("down_events", ev_seen - ev0, 3);

    ev0 = ev_seen;
    btn = 4'b0001;
    repeat (3) step();
    btn = 4'b0000;
    repeat (10) step();
    chk("glitch_speed", o_FANspeed, 0);
    chk("glitch_events", ev_seen - ev0, 0);

    press(4'b0001);
    press(4'b0001);
    press(4'b1000);
    chk("arm_sel", o_timer_sel, TIMER_EN ? 1 : 0);
    chk("arm_active", o_timer_active, TIMER_EN ? 1 : 0);
    ev0 = ev_seen;
    repeat (20) step();
    chk("expire_speed", o_FANspeed, TIMER_EN ? 0 : 2);
    chk("expire_sel", o_timer_sel, 0);
    chk("expire_events", ev_seen - ev0, 0);

    press(4'b0100);
    repeat (3) press(4'b0001);
    repeat (2) press(4'b1000);
    chk("sel2", o_timer_sel, TIMER_EN ? 2 : 0);
    press(4'b0100);
    chk("off_speed", o_FANspeed, 0);
    chk("off_sel", o_timer_sel, 0);
    press(4'b1000);
    chk("tmr_at_zero", o_timer_sel, 0);
    press(4'b0001);
    press(4'b0011);
    chk("up_down_same", o_FANspeed, 1);

    // Reset mid-countdown, then mid-debounce with the button held through it.
    press(4'b1000);
    repeat (5) step();
    do_reset();
    btn = 4'b0001;
    repeat (3) step();
    do_reset();
    repeat (7) step();
    chk("post_rst_early", o_FANspeed, 0);
    step();
    chk("post_rst_speed", o_FANspeed, 1);
    btn = 4'b0000;
    repeat (D + 3) step();

    repeat (160) begin
      if ($urandom_range(0, 9) < 6) m = 4'b0001 << $urandom_range(0, 3);
      else m = 4'($urandom_range(0, 15));
      btn = m;
      repeat ($urandom_range(1, 9)) step();
      btn = 4'b0000;
      repeat ($urandom_range(1, 8)) step();
      if ($urandom_range(0, 15) == 0) repeat (65) step();
      if ($urandom_range(0, 40) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
